// File: rtl/ssp_tx_fetch_ctrl.sv
// ============================================================================
// ssp_tx_fetch_ctrl : SSP transmit fetch sequencer (FIFO head -> justifier -> shifter)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ssp_tx_fetch_ctrl (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       SSE,
  input  logic [1:0] FRF,
  input  logic [3:0] DSS,
  input  logic       MS,
  input  logic       TxFEmpty,
  input  logic       TxDataReq,
  output logic [1:0] FRFPCLK,
  output logic [3:0] DSSPCLK,
  output logic       MSPCLK,
  output logic       TxFRdPop,
  output logic       TxDataVld,
  output logic       TxBusy,
  output logic       DssErr
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_READY  = 3'd2,
    S_POP    = 3'd3,
    S_SETTLE = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   cfg_ld;

  always_comb begin
    state_nxt = state;
    cfg_ld    = 1'b0;
    case (state)
      S_IDLE: begin
        if (SSE && !TxFEmpty) begin
          state_nxt = S_LOAD;
          cfg_ld    = 1'b1;
        end
      end
      S_LOAD: begin
        if (!SSE)                  state_nxt = S_IDLE;
        else if (DSSPCLK < 4'd3)   state_nxt = S_POP;
        else                       state_nxt = S_READY;
      end
      S_READY: begin
        // A request in the same cycle as disable still retires the word
        if (TxDataReq)             state_nxt = S_POP;
        else if (!SSE)             state_nxt = S_IDLE;
      end
      S_POP: begin
        state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (SSE && !TxFEmpty) begin
          state_nxt = S_LOAD;
          cfg_ld    = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= S_IDLE;
      FRFPCLK <= 2'b00;
      DSSPCLK <= 4'h0;
      MSPCLK  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cfg_ld) begin
        FRFPCLK <= FRF;
        DSSPCLK <= DSS;
        MSPCLK  <= MS;
      end
    end
  end

  // Config is frozen from LOAD onward, so a short DSS in POP can only mean a discard
  assign TxDataVld = (state == S_READY);
  assign TxFRdPop  = (state == S_POP);
  assign TxBusy    = (state != S_IDLE);
  assign DssErr    = (state == S_POP) && (DSSPCLK < 4'd3);

endmodule

`default_nettype wire

// File: tb/tb_ssp_tx_fetch_ctrl.sv
// ============================================================================
// tb_ssp_tx_fetch_ctrl : directed self-checking bench for ssp_tx_fetch_ctrl
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ssp_tx_fetch_ctrl;

  logic       PCLK;
  logic       PRESETn;
  logic       SSE;
  logic [1:0] FRF;
  logic [3:0] DSS;
  logic       MS;
  logic       TxFEmpty;
  logic       TxDataReq;
  logic [1:0] FRFPCLK;
  logic [3:0] DSSPCLK;
  logic       MSPCLK;
  logic       TxFRdPop;
  logic       TxDataVld;
  logic       TxBusy;
  logic       DssErr;

  int n_cmp = 0;
  int n_err = 0;
  int push_cnt = 0;
  int pop_cnt  = 0;

  ssp_tx_fetch_ctrl dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .SSE       (SSE),
    .FRF       (FRF),
    .DSS       (DSS),
    .MS        (MS),
    .TxFEmpty  (TxFEmpty),
    .TxDataReq (TxDataReq),
    .FRFPCLK   (FRFPCLK),
    .DSSPCLK   (DSSPCLK),
    .MSPCLK    (MSPCLK),
    .TxFRdPop  (TxFRdPop),
    .TxDataVld (TxDataVld),
    .TxBusy    (TxBusy),
    .DssErr    (DssErr)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // FIFO occupancy model: words pushed by the stimulus minus pops seen at the clock edge
  always @(posedge PCLK) if (TxFRdPop) pop_cnt <= pop_cnt + 1;
  assign TxFEmpty = (push_cnt == pop_cnt);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int pops;
  int pc [3];
  int pop_base;
  logic v1, v2;

  initial begin
    PRESETn   = 1'b0;
    SSE       = 1'b0;
    FRF       = 2'b00;
    DSS       = 4'h0;
    MS        = 1'b0;
    TxDataReq = 1'b0;
    step_n(3);
    chk("rst_busy", TxBusy, 0);
    chk("rst_vld", TxDataVld, 0);
    chk("rst_pop", TxFRdPop, 0);
    chk("rst_dss", DSSPCLK, 0);
    PRESETn = 1'b1;
    step_n(2);

    // ---- single word, DSS=7 ----
    SSE = 1'b1; DSS = 4'h7;
    push_cnt = push_cnt + 1;              // cycle 0
    chk("t1_c0_busy", TxBusy, 0);
    step();                               // cycle 1
    chk("t1_c1_dss", DSSPCLK, 7);
    chk("t1_c1_busy", TxBusy, 1);
    chk("t1_c1_vld", TxDataVld, 0);
    step();                               // cycle 2
    chk("t1_c2_vld", TxDataVld, 1);
    step_n(3);                            // cycle 5
    chk("t1_c5_vld", TxDataVld, 1);
    chk("t1_c5_pop", TxFRdPop, 0);
    TxDataReq = 1'b1;
    step();                               // cycle 6
    TxDataReq = 1'b0;
    chk("t1_c6_pop", TxFRdPop, 1);
    chk("t1_c6_vld", TxDataVld, 0);
    chk("t1_c6_err", DssErr, 0);
    step();                               // cycle 7
    chk("t1_c7_pop", TxFRdPop, 0);
    chk("t1_c7_busy", TxBusy, 1);
    step();                               // cycle 8
    chk("t1_c8_busy", TxBusy, 0);
    step_n(2);

    // ---- back-to-back, 3 words, DSS=F ----
    DSS = 4'hF;
    push_cnt = push_cnt + 3;
    pops = 0; pc[0] = 0; pc[1] = 0; pc[2] = 0;
    v1 = 1'b0; v2 = 1'b0;
    for (int c = 0; c < 22; c++) begin
      TxDataReq = v1 && !v2;
      if (TxFRdPop) begin
        if (pops < 3) pc[pops] = c;
        pops++;
        chk("t2_vld_in_pop", TxDataVld, 0);
      end
      v2 = v1;
      v1 = TxDataVld;
      step();
    end
    TxDataReq = 1'b0;
    chk("t2_pops", pops, 3);
    chk("t2_first_pop", pc[0], 4);
    chk("t2_gap01", pc[1] - pc[0], 5);
    chk("t2_gap12", pc[2] - pc[1], 5);
    chk("t2_idle", TxBusy, 0);
    step();

    // ---- invalid size DSS=2 ----
    DSS = 4'h2;
    push_cnt = push_cnt + 1;              // cycle 0
    step();                               // cycle 1
    chk("t3_c1_vld", TxDataVld, 0);
    chk("t3_c1_dss", DSSPCLK, 2);
    step();                               // cycle 2
    chk("t3_c2_pop", TxFRdPop, 1);
    chk("t3_c2_err", DssErr, 1);
    chk("t3_c2_vld", TxDataVld, 0);
    step();                               // cycle 3
    chk("t3_c3_err", DssErr, 0);
    chk("t3_c3_pop", TxFRdPop, 0);
    step();                               // cycle 4
    chk("t3_c4_busy", TxBusy, 0);
    chk("t3_empty", TxFEmpty, 1);
    step();

    // ---- config stability: DSS 7 -> 11 in READY ----
    DSS = 4'h7;
    push_cnt = push_cnt + 2;              // cycle 0
    step_n(2);                            // cycle 2 READY
    chk("t4_c2_vld", TxDataVld, 1);
    DSS = 4'd11;
    step();                               // cycle 3
    chk("t4_c3_dss", DSSPCLK, 7);
    TxDataReq = 1'b1;
    step();                               // cycle 4 POP
    TxDataReq = 1'b0;
    chk("t4_c4_dss", DSSPCLK, 7);
    chk("t4_c4_err", DssErr, 0);
    step();                               // cycle 5 SETTLE
    chk("t4_c5_dss", DSSPCLK, 7);
    step();                               // cycle 6 LOAD
    chk("t4_c6_dss", DSSPCLK, 11);
    step();                               // cycle 7 READY
    chk("t4_c7_vld", TxDataVld, 1);
    TxDataReq = 1'b1;
    step();                               // cycle 8 POP
    TxDataReq = 1'b0;
    step_n(2);                            // cycle 10
    chk("t4_idle", TxBusy, 0);

    // ---- disable mid-word ----
    DSS = 4'h7;
    push_cnt = push_cnt + 1;              // cycle 0
    pop_base = pop_cnt;
    step_n(2);                            // cycle 2 READY
    chk("t5_c2_vld", TxDataVld, 1);
    SSE = 1'b0;
    step();                               // cycle 3
    chk("t5_c3_busy", TxBusy, 0);
    chk("t5_c3_vld", TxDataVld, 0);
    chk("t5_no_pop", pop_cnt - pop_base, 0);
    SSE = 1'b1;
    step();                               // cycle 4 LOAD
    chk("t5_c4_vld", TxDataVld, 0);
    step();                               // cycle 5 READY again
    chk("t5_c5_vld", TxDataVld, 1);
    TxDataReq = 1'b1;
    step();                               // cycle 6 POP
    TxDataReq = 1'b0;
    chk("t5_c6_pop", TxFRdPop, 1);
    step_n(2);
    chk("t5_idle", TxBusy, 0);

    // ---- async reset during POP ----
    FRF = 2'b10; MS = 1'b1;
    push_cnt = push_cnt + 1;              // cycle 0
    step();                               // cycle 1
    chk("t6_c1_frf", FRFPCLK, 2);
    chk("t6_c1_ms", MSPCLK, 1);
    step();                               // cycle 2 READY
    TxDataReq = 1'b1;
    step();                               // cycle 3 POP
    TxDataReq = 1'b0;
    chk("t6_c3_pop", TxFRdPop, 1);
    #2;
    PRESETn = 1'b0;
    push_cnt = pop_cnt;                   // FIFO flushed alongside the reset
    #1;
    chk("t6_rst_pop", TxFRdPop, 0);
    chk("t6_rst_busy", TxBusy, 0);
    chk("t6_rst_frf", FRFPCLK, 0);
    chk("t6_rst_ms", MSPCLK, 0);
    chk("t6_rst_dss", DSSPCLK, 0);
    chk("t6_rst_err", DssErr, 0);
    pop_base = pop_cnt;
    step_n(2);
    PRESETn = 1'b1;
    step_n(5);
    chk("t6_no_pop", pop_cnt - pop_base, 0);
    chk("t6_idle", TxBusy, 0);
    push_cnt = push_cnt + 1;              // cycle 0
    step();                               // cycle 1 LOAD
    chk("t6_reload_busy", TxBusy, 1);
    chk("t6_reload_frf", FRFPCLK, 2);
    step();
    TxDataReq = 1'b1;
    step();
    TxDataReq = 1'b0;
    step_n(3);
    chk("t6_end_idle", TxBusy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
